// File: rtl/nvme_io_issue.sv
// NVMe I/O issue: writes one 64-byte SQ entry as four 128-bit Tx beats, then rings the SQ tail doorbell.
// Latency: beats 1..4 cycles and doorbell 5 cycles after accept; cmd_ready low while busy or action has no credit.
module nvme_io_issue #(
  parameter int ACTION_ID_BITS = 4,
  parameter int REQ_ID_BITS    = 8,
  parameter int TRACK_NUM      = 16,
  parameter int SQ_PTR_BITS    = 4,
  localparam int TX_ADDR_BITS  = 4 + SQ_PTR_BITS + 2
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic                        issue_enable,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ACTION_ID_BITS-1:0]   cmd_action_id,
  input  logic [3:0]                  cmd_sq_id,
  input  logic [7:0]                  cmd_opcode,
  input  logic [63:0]                 cmd_slba,
  input  logic [15:0]                 cmd_nlb,
  input  logic [63:0]                 cmd_prp1,
  input  logic [63:0]                 cmd_prp2,
  input  logic                        release_valid,
  input  logic [ACTION_ID_BITS-1:0]   release_action_id,
  output logic                        tx_write_valid,
  output logic [TX_ADDR_BITS-1:0]     tx_waddr,
  output logic [127:0]                tx_wdata,
  output logic                        doorbell_valid,
  output logic [3:0]                  doorbell_sq_id,
  output logic [SQ_PTR_BITS-1:0]      doorbell_tail,
  output logic [2**ACTION_ID_BITS-1:0] outstanding
);

  localparam int NUM_ACT     = 2**ACTION_ID_BITS;
  localparam int CNT_BITS    = $clog2(TRACK_NUM) + 1;
  localparam int CMD_ID_BITS = REQ_ID_BITS + ACTION_ID_BITS + 4;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_DOORBELL = 2'd2;

  logic [1:0]             state;
  logic [1:0]             beat;
  logic [1:0]             next_beat;
  logic [3:0]             sq_q;
  logic [7:0]             opcode_q;
  logic [CMD_ID_BITS-1:0] cmd_id_q;
  logic [CMD_ID_BITS-1:0] cmd_id_in;
  logic [63:0]            slba_q;
  logic [15:0]            nlb_q;
  logic [63:0]            prp1_q;
  logic [63:0]            prp2_q;
  logic [SQ_PTR_BITS-1:0] tail_inc;
  logic                   accept;

  logic [REQ_ID_BITS-1:0] req_idx [NUM_ACT];
  logic [CNT_BITS-1:0]    out_cnt [NUM_ACT];
  logic [CNT_BITS-1:0]    cnt_nxt [NUM_ACT];
  logic [SQ_PTR_BITS-1:0] tail    [16];

  function automatic logic [127:0] fmt_beat(
    input logic [1:0]   b,
    input logic [7:0]   op,
    input logic [15:0]  cid,
    input logic [63:0]  slba,
    input logic [15:0]  nlb,
    input logic [63:0]  prp1,
    input logic [63:0]  prp2
  );
    logic [127:0] d;
    d = '0;
    case (b)
      2'd0: begin
        d[7:0]   = op;
        d[31:16] = cid;
        d[63:32] = 32'd1;
      end
      2'd1: d[127:64] = prp1;
      2'd2: begin
        d[63:0]   = prp2;
        d[127:64] = slba;
      end
      default: d[15:0] = nlb;
    endcase
    return d;
  endfunction

  assign cmd_ready = axi_aresetn && issue_enable && (state == S_IDLE) &&
                     (out_cnt[cmd_action_id] < CNT_BITS'(TRACK_NUM));
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_id_in = {req_idx[cmd_action_id], cmd_action_id, cmd_sq_id};
  assign next_beat = beat + 2'd1;
  assign tail_inc  = tail[sq_q] + SQ_PTR_BITS'(1);

  // Output registers are loaded on the edge entering each state, so they line up with the state.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state          <= S_IDLE;
      beat           <= '0;
      sq_q           <= '0;
      opcode_q       <= '0;
      cmd_id_q       <= '0;
      slba_q         <= '0;
      nlb_q          <= '0;
      prp1_q         <= '0;
      prp2_q         <= '0;
      tx_write_valid <= 1'b0;
      tx_waddr       <= '0;
      tx_wdata       <= '0;
      doorbell_valid <= 1'b0;
      doorbell_sq_id <= '0;
      doorbell_tail  <= '0;
      for (int i = 0; i < NUM_ACT; i++) req_idx[i] <= '0;
      for (int i = 0; i < 16; i++) tail[i] <= '0;
    end else begin
      tx_write_valid <= 1'b0;
      doorbell_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_WRITE;
            beat     <= 2'd0;
            sq_q     <= cmd_sq_id;
            opcode_q <= cmd_opcode;
            cmd_id_q <= cmd_id_in;
            slba_q   <= cmd_slba;
            nlb_q    <= cmd_nlb;
            prp1_q   <= cmd_prp1;
            prp2_q   <= cmd_prp2;
            req_idx[cmd_action_id] <=
              (req_idx[cmd_action_id] == REQ_ID_BITS'(TRACK_NUM - 1)) ? '0
                                                                      : req_idx[cmd_action_id] + 1'b1;
            tx_write_valid <= 1'b1;
            tx_waddr       <= {cmd_sq_id, tail[cmd_sq_id], 2'd0};
            tx_wdata       <= fmt_beat(2'd0, cmd_opcode, 16'(cmd_id_in), cmd_slba,
                                       cmd_nlb, cmd_prp1, cmd_prp2);
          end
        end
        S_WRITE: begin
          if (beat == 2'd3) begin
            state          <= S_DOORBELL;
            doorbell_valid <= 1'b1;
            doorbell_sq_id <= sq_q;
            doorbell_tail  <= tail_inc;
            tail[sq_q]     <= tail_inc;
          end else begin
            beat           <= next_beat;
            tx_write_valid <= 1'b1;
            tx_waddr       <= {sq_q, tail[sq_q], next_beat};
            tx_wdata       <= fmt_beat(next_beat, opcode_q, 16'(cmd_id_q), slba_q,
                                       nlb_q, prp1_q, prp2_q);
          end
        end
        S_DOORBELL: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // A release against an empty count is dropped; accept and release together cancel.
  always_comb begin
    for (int a = 0; a < NUM_ACT; a++) begin
      cnt_nxt[a] = out_cnt[a];
      if ((accept && (cmd_action_id == ACTION_ID_BITS'(a))) &&
          !(release_valid && (release_action_id == ACTION_ID_BITS'(a)) && (out_cnt[a] != '0)))
        cnt_nxt[a] = out_cnt[a] + 1'b1;
      else if (!(accept && (cmd_action_id == ACTION_ID_BITS'(a))) &&
               (release_valid && (release_action_id == ACTION_ID_BITS'(a)) && (out_cnt[a] != '0)))
        cnt_nxt[a] = out_cnt[a] - 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      outstanding <= '0;
      for (int a = 0; a < NUM_ACT; a++) out_cnt[a] <= '0;
    end else begin
      for (int a = 0; a < NUM_ACT; a++) begin
        out_cnt[a]     <= cnt_nxt[a];
        outstanding[a] <= (cnt_nxt[a] != '0);
      end
    end
  end

endmodule

// File: tb/tb_nvme_io_issue.sv
// Scoreboard bench for nvme_io_issue: a queue-based reference model predicts beats and doorbells at accept time.
module tb_nvme_io_issue;

  logic         axi_aclk = 1'b0;
  logic         axi_aresetn = 1'b0;
  logic         issue_enable = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_action_id = '0;
  logic [3:0]   cmd_sq_id = '0;
  logic [7:0]   cmd_opcode = '0;
  logic [63:0]  cmd_slba = '0;
  logic [15:0]  cmd_nlb = '0;
  logic [63:0]  cmd_prp1 = '0;
  logic [63:0]  cmd_prp2 = '0;
  logic         release_valid = 1'b0;
  logic [3:0]   release_action_id = '0;
  logic         tx_write_valid;
  logic [9:0]   tx_waddr;
  logic [127:0] tx_wdata;
  logic         doorbell_valid;
  logic [3:0]   doorbell_sq_id;
  logic [3:0]   doorbell_tail;
  logic [15:0]  outstanding;

  nvme_io_issue dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .issue_enable(issue_enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_action_id(cmd_action_id),
    .cmd_sq_id(cmd_sq_id), .cmd_opcode(cmd_opcode), .cmd_slba(cmd_slba), .cmd_nlb(cmd_nlb),
    .cmd_prp1(cmd_prp1), .cmd_prp2(cmd_prp2), .release_valid(release_valid),
    .release_action_id(release_action_id), .tx_write_valid(tx_write_valid),
    .tx_waddr(tx_waddr), .tx_wdata(tx_wdata), .doorbell_valid(doorbell_valid),
    .doorbell_sq_id(doorbell_sq_id), .doorbell_tail(doorbell_tail), .outstanding(outstanding)
  );

  always #5 axi_aclk = ~axi_aclk;

  int cyc = 0;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]   addr;
    logic [127:0] data;
    int           cyc;
  } wr_t;
  typedef struct {
    logic [3:0] sq;
    logic [3:0] tail;
    int         cyc;
  } db_t;

  wr_t wr_q[$];
  db_t db_q[$];
  wr_t mon_w;
  db_t mon_d;

  // Reference model: per-action request index and credit count, per-SQ tail, busy cycles left.
  int m_ridx[16];
  int m_cnt[16];
  int m_tail[16];
  int m_busy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ridx[i] = 0;
      m_cnt[i]  = 0;
      m_tail[i] = 0;
    end
    m_busy = 0;
    wr_q.delete();
    db_q.delete();
  endtask

  // One clock: check ready/outstanding against the model, predict any accepted command.
  task automatic tick(output bit acc);
    bit            rdy_exp;
    bit            dec;
    logic [15:0]   out_exp;
    logic [15:0]   cid;
    logic [127:0]  d;
    int            t;
    @(negedge axi_aclk);
    for (int i = 0; i < 16; i++) out_exp[i] = (m_cnt[i] != 0);
    chk("outstanding", outstanding, out_exp);
    rdy_exp = issue_enable && (m_busy == 0) && (m_cnt[cmd_action_id] < 16);
    chk("cmd_ready", cmd_ready, rdy_exp);
    acc = cmd_valid && rdy_exp;
    dec = release_valid && (m_cnt[release_action_id] != 0);
    if (acc) begin
      cid = {8'(m_ridx[cmd_action_id]), cmd_action_id, cmd_sq_id};
      m_ridx[cmd_action_id] = (m_ridx[cmd_action_id] + 1) % 16;
      t = m_tail[cmd_sq_id];
      for (int b = 0; b < 4; b++) begin
        case (b)
          0:       d = {64'd0, 32'd1, cid, 8'd0, cmd_opcode};
          1:       d = {cmd_prp1, 64'd0};
          2:       d = {cmd_slba, cmd_prp2};
          default: d = {112'd0, cmd_nlb};
        endcase
        wr_q.push_back('{addr: {cmd_sq_id, 4'(t), 2'(b)}, data: d, cyc: cyc + 1 + b});
      end
      m_tail[cmd_sq_id] = (t + 1) % 16;
      db_q.push_back('{sq: cmd_sq_id, tail: 4'(m_tail[cmd_sq_id]), cyc: cyc + 5});
      m_busy = 5;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (acc) m_cnt[cmd_action_id]++;
    if (dec) m_cnt[release_action_id]--;
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] a, input logic [3:0] sq, input logic [7:0] op);
    cmd_action_id = a;
    cmd_sq_id     = sq;
    cmd_opcode    = op;
    cmd_slba      = {$urandom, $urandom};
    cmd_nlb       = 16'($urandom);
    cmd_prp1      = {$urandom, $urandom};
    cmd_prp2      = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] sq, input logic [7:0] op);
    bit acc;
    int n;
    set_cmd(a, sq, op);
    cmd_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 12) begin
      tick(acc);
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: action %0d not accepted within 12 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tx_write_valid"}, tx_write_valid, 0);
    chk({tag, "_tx_waddr"}, tx_waddr, 0);
    chk({tag, "_tx_wdata"}, tx_wdata, 0);
    chk({tag, "_doorbell_valid"}, doorbell_valid, 0);
    chk({tag, "_doorbell_sq_id"}, doorbell_sq_id, 0);
    chk({tag, "_doorbell_tail"}, doorbell_tail, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  // Monitor: every write/doorbell the DUT presents must match the oldest prediction, on its cycle.
  always @(negedge axi_aclk) begin
    if (axi_aresetn) begin
      if (tx_write_valid) begin
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: write addr %0h data %0h, none expected", tx_waddr, tx_wdata);
        end else begin
          mon_w = wr_q.pop_front();
          chk("tx_waddr", tx_waddr, mon_w.addr);
          chk("tx_wdata", tx_wdata, mon_w.data);
          chk("tx_cycle", cyc, mon_w.cyc);
        end
      end
      if (doorbell_valid) begin
        if (db_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL doorbell_unexpected: sq %0d tail %0d, none expected", doorbell_sq_id, doorbell_tail);
        end else begin
          mon_d = db_q.pop_front();
          chk("doorbell_sq_id", doorbell_sq_id, mon_d.sq);
          chk("doorbell_tail", doorbell_tail, mon_d.tail);
          chk("doorbell_cycle", cyc, mon_d.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    model_reset();

    // Reset state, with a command pending to prove ready is held low.
    issue_enable = 1'b1;
    cmd_valid    = 1'b1;
    #12;
    check_zero_outputs("reset");
    @(posedge axi_aclk);
    #1;
    cmd_valid   = 1'b0;
    axi_aresetn = 1'b1;

    // Enable gating, then the basic issue on the cycle enable rises (cmd_id 0x0032).
    set_cmd(4'd3, 4'd2, 8'h02);
    cmd_slba     = 64'h100;
    cmd_nlb      = 16'd7;
    issue_enable = 1'b0;
    cmd_valid    = 1'b1;
    idle(3);
    issue_enable = 1'b1;
    tick(acc);
    cmd_valid = 1'b0;
    idle(6);

    // Credit stall on action 1, then wrap of req_id after one release.
    for (int i = 0; i < 16; i++) issue(4'd1, 4'(i % 4), 8'h01);
    idle(6);
    cmd_action_id = 4'd1;
    cmd_valid     = 1'b1;
    idle(2);
    cmd_valid     = 1'b0;
    cmd_action_id = 4'd2;
    idle(1);
    release_valid     = 1'b1;
    release_action_id = 4'd1;
    idle(1);
    release_valid = 1'b0;
    issue(4'd1, 4'd3, 8'h02);
    idle(6);
    release_valid = 1'b1;
    idle(17);
    release_valid = 1'b0;

    // Simultaneous accept/release on one action, and release at zero.
    issue(4'd4, 4'd7, 8'h01);
    idle(6);
    set_cmd(4'd4, 4'd7, 8'h02);
    cmd_valid         = 1'b1;
    release_valid     = 1'b1;
    release_action_id = 4'd4;
    tick(acc);
    cmd_valid = 1'b0;
    release_valid = 1'b0;
    idle(6);
    release_valid = 1'b1;
    idle(3);
    release_valid = 1'b0;
    idle(2);

    // Tail wrap on sq 5 with releases interleaved.
    for (int i = 0; i < 17; i++) begin
      issue(4'd6, 4'd5, 8'h01);
      release_valid     = 1'b1;
      release_action_id = 4'd6;
      idle(1);
      release_valid = 1'b0;
    end
    idle(6);

    // Reset after beat 1 has been presented.
    issue(4'd3, 4'd9, 8'h02);
    idle(1);
    @(negedge axi_aclk);
    #2;
    axi_aresetn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    @(posedge axi_aclk);
    @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    issue(4'd3, 4'd2, 8'h02);
    idle(8);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      set_cmd(4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom));
      cmd_valid         = ($urandom_range(0, 9) < 7);
      issue_enable      = ($urandom_range(0, 19) != 0);
      release_valid     = ($urandom_range(0, 9) < 4);
      release_action_id = 4'($urandom_range(0, 3));
      tick(acc);
    end
    cmd_valid     = 1'b0;
    release_valid = 1'b0;
    issue_enable  = 1'b1;
    idle(10);

    chk("tx_queue_drained", 32'(wr_q.size()), 0);
    chk("doorbell_queue_drained", 32'(db_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
